// File: rtl/seg7_scan_drv.sv
// -----------------------------------------------------------------------------
// seg7_scan_drv
//
// Four-digit multiplexed seven-segment display driver. The slow scan reference
// (a divider output synchronous to CLK) advances one digit per rising edge.
// A blanking gap of BLANK_CYC cycles follows every digit advance to suppress
// ghosting. Display data is double-buffered: LOAD captures into a pending
// buffer, which is committed to the active buffer only when the digit index
// wraps from 3 to 0.
//
// Ports:
//   CLK       system clock (only clock)
//   RST_N     asynchronous active-low reset
//   SCAN_CLK  scan reference; each rising edge advances one digit
//   DATA      four hex nibbles, DATA[3:0] is digit 0 (rightmost)
//   DP        decimal points, DP[i] belongs to digit i
//   LOAD      one-cycle strobe capturing DATA/DP into the pending buffer
//   SEG       segment drive {dp,g,f,e,d,c,b,a}
//   DIG       digit enables, one-hot while showing
//   FRAME     one-cycle pulse in the cycle after the index wraps 3 -> 0
// -----------------------------------------------------------------------------
module seg7_scan_drv #(
    parameter int unsigned BLANK_CYC   = 4,
    parameter int unsigned LZ_SUPPRESS = 0,
    parameter int unsigned SEG_ACT_LOW = 1,
    parameter int unsigned COM_ACT_LOW = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SCAN_CLK,
    input  logic [15:0] DATA,
    input  logic [3:0]  DP,
    input  logic        LOAD,
    output logic [7:0]  SEG,
    output logic [3:0]  DIG,
    output logic        FRAME
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [7:0] BLANK_LAST = (BLANK_CYC == 0) ? 8'd0 : 8'(BLANK_CYC - 1);
    localparam logic [7:0] SEG_OFF    = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_OFF    = (COM_ACT_LOW != 0) ? 4'hF : 4'h0;

    // Active-high {g,f,e,d,c,b,a} pattern for a hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // Digit i is a leading zero when it and every higher nibble are zero.
    // Digit 0 is never suppressed so a zero value still shows "0".
    function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] i);
        logic z;
        case (i)
            2'd1:    z = (d[15:4] == 12'h000);
            2'd2:    z = (d[15:8] == 8'h00);
            2'd3:    z = (d[15:12] == 4'h0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    logic        scan_d;
    logic [1:0]  idx;
    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] act_data;
    logic [3:0]  act_dp;
    logic [15:0] pend_data;
    logic [3:0]  pend_dp;
    logic        pend;

    logic        rise;
    logic        wrap;
    logic [1:0]  idx_nx;
    state_t      state_nx;
    logic [7:0]  cnt_nx;
    logic [15:0] act_data_nx;
    logic [3:0]  act_dp_nx;
    logic [15:0] pend_data_nx;
    logic [3:0]  pend_dp_nx;
    logic        pend_nx;
    logic [3:0]  nib;
    logic [7:0]  seg_raw;
    logic [3:0]  dig_raw;
    logic [7:0]  seg_nx;
    logic [3:0]  dig_nx;

    // SCAN_CLK is already synchronous to CLK, so a single delay suffices.
    assign rise = SCAN_CLK & ~scan_d;
    assign wrap = rise && (idx == 2'd3);

    // Next-state: digit sequencing and blanking.
    always_comb begin
        idx_nx   = idx;
        state_nx = state;
        cnt_nx   = cnt;
        if (rise) begin
            idx_nx   = idx + 2'd1;
            cnt_nx   = 8'd0;
            state_nx = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
        end else if (state == ST_BLANK) begin
            cnt_nx = cnt + 8'd1;
            if ((BLANK_CYC == 0) || (cnt == BLANK_LAST)) begin
                state_nx = ST_SHOW;
            end
        end
    end

    // Double buffer. A LOAD coinciding with the wrap still lands in pending;
    // the wrap commits only what was pending before that LOAD.
    always_comb begin
        act_data_nx  = act_data;
        act_dp_nx    = act_dp;
        pend_data_nx = pend_data;
        pend_dp_nx   = pend_dp;
        pend_nx      = pend;
        if (wrap && pend) begin
            act_data_nx = pend_data;
            act_dp_nx   = pend_dp;
            pend_nx     = 1'b0;
        end
        if (LOAD) begin
            pend_data_nx = DATA;
            pend_dp_nx   = DP;
            pend_nx      = 1'b1;
        end
    end

    // Outputs are registered from next-state values so the blank gap is
    // exactly BLANK_CYC cycles and a fresh commit is visible immediately.
    always_comb begin
        nib     = 4'(act_data_nx >> {idx_nx, 2'b00});
        seg_raw = {act_dp_nx[idx_nx], hex7(nib)};
        if ((LZ_SUPPRESS != 0) && lead_zero(act_data_nx, idx_nx)) begin
            seg_raw[6:0] = 7'h00;
        end
        dig_raw = 4'b0001 << idx_nx;
        if (state_nx == ST_BLANK) begin
            seg_raw = 8'h00;
            dig_raw = 4'h0;
        end
        seg_nx = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
        dig_nx = (COM_ACT_LOW != 0) ? ~dig_raw : dig_raw;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scan_d    <= 1'b0;
            idx       <= 2'd0;
            state     <= ST_BLANK;
            cnt       <= 8'd0;
            act_data  <= 16'h0000;
            act_dp    <= 4'h0;
            pend_data <= 16'h0000;
            pend_dp   <= 4'h0;
            pend      <= 1'b0;
            SEG       <= SEG_OFF;
            DIG       <= DIG_OFF;
            FRAME     <= 1'b0;
        end else begin
            scan_d    <= SCAN_CLK;
            idx       <= idx_nx;
            state     <= state_nx;
            cnt       <= cnt_nx;
            act_data  <= act_data_nx;
            act_dp    <= act_dp_nx;
            pend_data <= pend_data_nx;
            pend_dp   <= pend_dp_nx;
            pend      <= pend_nx;
            SEG       <= seg_nx;
            DIG       <= dig_nx;
            FRAME     <= wrap;
        end
    end

endmodule
